// File: rtl/niosii_system_sysid_checker.sv
// Reads the sysid ID word (address 0) and timestamp word (address 1) over Avalon-MM and compares them
// with EXPECTED_ID / EXPECTED_TS. Define SYSID_CHECKER_TIMEOUT_EN to add a per-read wait-cycle timeout.
module niosii_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1490753526,
   parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_ID = 3'd1,
      WT_ID = 3'd2,
      RD_TS = 3'd3,
      WT_TS = 3'd4,
      FIN   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic        avm_read_q, avm_read_d;
   logic        avm_address_q, avm_address_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;
   logic        expire_s;

   if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd255)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 1..255");
   end

`ifdef SYSID_CHECKER_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];
   logic [7:0] wait_cnt_q, wait_cnt_d;

   assign expire_s = (wait_cnt_q == TIMEOUT_LIM);

   // Wait counter: restarts on entry to each read request, saturates at the limit.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (((state_d == RD_ID) && (state_q != RD_ID)) || ((state_d == RD_TS) && (state_q != RD_TS))) begin
         wait_cnt_d = 8'd0;
      end else if ((state_q == RD_ID || state_q == WT_ID || state_q == RD_TS || state_q == WT_TS)
                   && (wait_cnt_q != TIMEOUT_LIM)) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   // Wait counter register.
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= 8'd0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   assign expire_s = 1'b0;
`endif

   // Next state and result capture; readdatavalid only matters in the read/wait states.
   always_comb begin
      state_d    = state_q;
      id_ok_d    = id_ok_q;
      ts_ok_d    = ts_ok_q;
      timeout_d  = timeout_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RD_ID;
               id_ok_d    = 1'b0;
               ts_ok_d    = 1'b0;
               timeout_d  = 1'b0;
               id_value_d = 32'd0;
               ts_value_d = 32'd0;
            end else begin
               state_d = IDLE;
            end
         end
         RD_ID, WT_ID: begin
            if (expire_s) begin
               state_d   = FIN;
               timeout_d = 1'b1;
            end else if (((state_q == RD_ID) && !avm_waitrequest && avm_readdatavalid)
                         || ((state_q == WT_ID) && avm_readdatavalid)) begin
               state_d    = RD_TS;
               id_value_d = avm_readdata;
               id_ok_d    = (avm_readdata == EXPECTED_ID);
            end else if ((state_q == RD_ID) && !avm_waitrequest) begin
               state_d = WT_ID;
            end else begin
               state_d = state_q;
            end
         end
         RD_TS, WT_TS: begin
            if (expire_s) begin
               state_d   = FIN;
               timeout_d = 1'b1;
            end else if (((state_q == RD_TS) && !avm_waitrequest && avm_readdatavalid)
                         || ((state_q == WT_TS) && avm_readdatavalid)) begin
               state_d    = FIN;
               ts_value_d = avm_readdata;
               ts_ok_d    = (avm_readdata == EXPECTED_TS);
            end else if ((state_q == RD_TS) && !avm_waitrequest) begin
               state_d = WT_TS;
            end else begin
               state_d = state_q;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Bus and status outputs decoded from the upcoming state so they can be registered.
   always_comb begin
      avm_read_d    = 1'b0;
      avm_address_d = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      case (state_d)
         IDLE: begin
            busy_d = 1'b0;
         end
         RD_ID: begin
            avm_read_d = 1'b1;
            busy_d     = 1'b1;
         end
         WT_ID: begin
            busy_d = 1'b1;
         end
         RD_TS: begin
            avm_read_d    = 1'b1;
            avm_address_d = 1'b1;
            busy_d        = 1'b1;
         end
         WT_TS: begin
            avm_address_d = 1'b1;
            busy_d        = 1'b1;
         end
         FIN: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         avm_read_q    <= 1'b0;
         avm_address_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         timeout_q     <= 1'b0;
         id_value_q    <= 32'd0;
         ts_value_q    <= 32'd0;
      end else begin
         state_q       <= state_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         timeout_q     <= timeout_d;
         id_value_q    <= id_value_d;
         ts_value_q    <= ts_value_d;
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for niosii_system_sysid_checker with a small configurable Avalon-MM sysid slave.
module tb_niosii_system_sysid_checker;

   localparam logic [31:0] EXP_TS = 32'd1490753526;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   int n_checks = 0;
   int n_fail   = 0;

   // slave configuration and state
   logic [31:0] slv_mem [2];
   int          cfg_wait  = 0;
   int          cfg_lat   = 0;
   bit          cfg_stuck = 1'b0;
   int          ws_cnt    = 0;
   int          pend      = 0;
   logic [31:0] pend_data = 32'd0;
   logic        slv_wait  = 1'b0;
   logic        slv_valid = 1'b0;
   logic [31:0] slv_data  = 32'd0;
   logic        stray_valid = 1'b0;
   logic [31:0] stray_data  = 32'd0;

   assign avm_waitrequest   = slv_wait;
   assign avm_readdatavalid = slv_valid | stray_valid;
   assign avm_readdata      = stray_valid ? stray_data : slv_data;

   niosii_system_sysid_checker #(
      .EXPECTED_ID    (32'd0),
      .EXPECTED_TS    (EXP_TS),
      .TIMEOUT_CYCLES (32'd4)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .busy              (busy),
      .done              (done),
      .id_ok             (id_ok),
      .ts_ok             (ts_ok),
      .timeout           (timeout),
      .id_value          (id_value),
      .ts_value          (ts_value)
   );

   always #5 clock = ~clock;

   // Slave drives on the falling edge so the DUT samples stable values on the rising edge.
   always @(negedge clock) begin
      if (reset) begin
         ws_cnt    <= 0;
         pend      <= 0;
         slv_wait  <= 1'b0;
         slv_valid <= 1'b0;
      end else if (avm_read === 1'b1) begin
         if (cfg_stuck || ws_cnt < cfg_wait) begin
            slv_wait  <= 1'b1;
            slv_valid <= 1'b0;
            if (!cfg_stuck) ws_cnt <= ws_cnt + 1;
         end else begin
            slv_wait <= 1'b0;
            ws_cnt   <= 0;
            if (cfg_lat == 0) begin
               slv_valid <= 1'b1;
               slv_data  <= slv_mem[avm_address];
               pend      <= 0;
            end else begin
               slv_valid <= 1'b0;
               pend      <= cfg_lat;
               pend_data <= slv_mem[avm_address];
            end
         end
      end else begin
         slv_wait <= 1'b0;
         if (pend > 0) begin
            pend      <= pend - 1;
            slv_valid <= (pend == 1);
            slv_data  <= pend_data;
         end else begin
            slv_valid <= 1'b0;
         end
      end
   end

   // Runs until done or budget; also tallies request-hold violations and busy gaps before done.
   task automatic run_seq(input bit do_start, input int budget, input int restart_at,
                          output int cycles, output bit got_done, output int hold_viol, output int busy_gap);
      logic prev_read, prev_addr;
      cycles = 0; got_done = 1'b0; hold_viol = 0; busy_gap = 0;
      prev_read = avm_read; prev_addr = avm_address;
      if (do_start) start = 1'b1;
      while (!got_done && cycles < budget) begin
         @(posedge clock); #1;
         cycles++;
         start = (cycles == restart_at);
         if (prev_read && avm_waitrequest && (avm_read !== 1'b1 || avm_address !== prev_addr)) hold_viol++;
         prev_read = avm_read; prev_addr = avm_address;
         if (done === 1'b1) got_done = 1'b1;
         else if (busy !== 1'b1) busy_gap++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_checks++;
      if ({busy, done, avm_read, avm_address, id_ok, ts_ok, timeout, id_value, ts_value} !== 71'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {busy, done, avm_read, avm_address, id_ok, ts_ok, timeout, id_value, ts_value});
      end
      start = 1'b0; reset = 1'b0;
      @(posedge clock); #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy %b expected 0", busy); end
   endtask

   task automatic test_zero_wait();
      int cyc, hv, bg; bit gd;
      cfg_wait = 0; cfg_lat = 0; slv_mem[0] = 32'd0; slv_mem[1] = EXP_TS;
      run_seq(1'b1, 20, 0, cyc, gd, hv, bg);
      n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL zw_done: got %b expected 1", gd); end
      n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL zw_latency: edges to done %0d expected 3", cyc); end
      n_checks++; if (id_ok !== 1'b1) begin n_fail++; $display("FAIL zw_id_ok: got %b expected 1", id_ok); end
      n_checks++; if (ts_ok !== 1'b1) begin n_fail++; $display("FAIL zw_ts_ok: got %b expected 1", ts_ok); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL zw_timeout: got %b expected 0", timeout); end
      n_checks++; if (ts_value !== EXP_TS) begin n_fail++; $display("FAIL zw_ts_value: got %h expected %h", ts_value, EXP_TS); end
      n_checks++; if (id_value !== 32'd0) begin n_fail++; $display("FAIL zw_id_value: got %h expected 0", id_value); end
      n_checks++; if (busy !== 1'b0 || bg !== 0) begin n_fail++; $display("FAIL zw_busy: busy %b gaps %0d expected 0/0", busy, bg); end
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zw_done_pulse: got %b expected 0", done); end
      n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL zw_read_idle: got %b expected 0", avm_read); end
   endtask

   task automatic test_wait_states();
      int cyc, hv, bg; bit gd;
      cfg_wait = 3; cfg_lat = 2; slv_mem[0] = 32'd0; slv_mem[1] = 32'h1234_5678;
      run_seq(1'b1, 40, 0, cyc, gd, hv, bg);
      n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL ws_done: got %b expected 1", gd); end
      n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL ws_latency: edges to done %0d expected 13", cyc); end
      n_checks++; if (hv !== 0) begin n_fail++; $display("FAIL ws_hold: violations %0d expected 0", hv); end
      n_checks++; if (bg !== 0) begin n_fail++; $display("FAIL ws_busy: gaps %0d expected 0", bg); end
      n_checks++; if (id_ok !== 1'b1) begin n_fail++; $display("FAIL ws_id_ok: got %b expected 1", id_ok); end
      n_checks++; if (ts_ok !== 1'b0) begin n_fail++; $display("FAIL ws_ts_ok: got %b expected 0", ts_ok); end
      n_checks++; if (ts_value !== 32'h1234_5678) begin n_fail++; $display("FAIL ws_ts_value: got %h expected 12345678", ts_value); end
      @(posedge clock); #1;
   endtask

`ifdef SYSID_CHECKER_TIMEOUT_EN
   task automatic test_timeout();
      int cyc, hv, bg; bit gd;
      cfg_wait = 0; cfg_lat = 0; cfg_stuck = 1'b1; slv_mem[0] = 32'd0; slv_mem[1] = EXP_TS;
      run_seq(1'b1, 20, 0, cyc, gd, hv, bg);
      n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL to_done: got %b expected 1", gd); end
      n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL to_latency: edges to done %0d expected 6", cyc); end
      n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", timeout); end
      n_checks++; if (id_ok !== 1'b0 || ts_ok !== 1'b0) begin n_fail++; $display("FAIL to_ok: id %b ts %b expected 0/0", id_ok, ts_ok); end
      n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL to_read_fin: got %b expected 0", avm_read); end
      @(posedge clock); #1;
      n_checks++; if ({avm_read, busy, done} !== 3'b000) begin n_fail++; $display("FAIL to_after: read/busy/done %b expected 000", {avm_read, busy, done}); end
      cfg_stuck = 1'b0;
      @(posedge clock); #1;
   endtask
`else
   task automatic test_no_timeout();
      int cyc, hv, bg; bit gd;
      cfg_wait = 0; cfg_lat = 0; cfg_stuck = 1'b1; slv_mem[0] = 32'd0; slv_mem[1] = EXP_TS;
      run_seq(1'b1, 300, 0, cyc, gd, hv, bg);
      n_checks++; if (gd !== 1'b0) begin n_fail++; $display("FAIL nt_no_done: got %b expected 0", gd); end
      n_checks++; if ({busy, avm_read, timeout} !== 3'b110) begin n_fail++; $display("FAIL nt_waiting: busy/read/timeout %b expected 110", {busy, avm_read, timeout}); end
      cfg_stuck = 1'b0;
      run_seq(1'b0, 20, 0, cyc, gd, hv, bg);
      n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL nt_done: got %b expected 1", gd); end
      n_checks++; if ({id_ok, ts_ok, timeout} !== 3'b110) begin n_fail++; $display("FAIL nt_flags: %b expected 110", {id_ok, ts_ok, timeout}); end
      @(posedge clock); #1;
   endtask
`endif

   task automatic test_repulse_stray();
      int cyc, hv, bg, extra; bit gd;
      cfg_wait = 1; cfg_lat = 1; slv_mem[0] = 32'd0; slv_mem[1] = EXP_TS;
      run_seq(1'b1, 40, 2, cyc, gd, hv, bg);
      n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL rp_done: got %b expected 1", gd); end
      start = 1'b1;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (busy !== 1'b0 || avm_read !== 1'b0 || done !== 1'b0) extra++;
      end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rp_no_second_seq: active cycles %0d expected 0", extra); end
      stray_data = 32'hDEAD_BEEF; stray_valid = 1'b1;
      repeat (2) @(posedge clock);
      #1; stray_valid = 1'b0;
      @(posedge clock); #1;
      n_checks++; if (id_value !== 32'd0 || ts_value !== EXP_TS) begin n_fail++; $display("FAIL stray_values: id %h ts %h expected 0/%h", id_value, ts_value, EXP_TS); end
      n_checks++; if ({id_ok, ts_ok, busy} !== 3'b110) begin n_fail++; $display("FAIL stray_flags: %b expected 110", {id_ok, ts_ok, busy}); end
   endtask

   task automatic test_reset_mid();
      int cyc, hv, bg, n; bit gd, hit, saw_done;
      cfg_wait = 0; cfg_lat = 3; slv_mem[0] = 32'hA5A5_0001; slv_mem[1] = EXP_TS;
      start = 1'b1; hit = 1'b0; n = 0;
      while (!hit && n < 30) begin
         @(posedge clock); #1;
         start = 1'b0; n++;
         if (busy === 1'b1 && avm_address === 1'b1 && avm_read === 1'b0) hit = 1'b1;
      end
      n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rm_reach_wt_ts: got %b expected 1", hit); end
      n_checks++; if (id_value !== 32'hA5A5_0001 || id_ok !== 1'b0) begin n_fail++; $display("FAIL rm_id_capture: %h/%b expected a5a50001/0", id_value, id_ok); end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      n_checks++;
      if ({busy, done, avm_read, avm_address, id_ok, ts_ok, timeout, id_value, ts_value} !== 71'd0) begin
         n_fail++;
         $display("FAIL rm_outputs: got %h expected 0",
                  {busy, done, avm_read, avm_address, id_ok, ts_ok, timeout, id_value, ts_value});
      end
      saw_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got %b expected 0", saw_done); end
      cfg_lat = 0; slv_mem[0] = 32'd0;
      run_seq(1'b1, 20, 0, cyc, gd, hv, bg);
      n_checks++; if (gd !== 1'b1 || cyc !== 3) begin n_fail++; $display("FAIL rm_restart: done %b edges %0d expected 1/3", gd, cyc); end
      n_checks++; if ({id_ok, ts_ok, timeout} !== 3'b110) begin n_fail++; $display("FAIL rm_flags: %b expected 110", {id_ok, ts_ok, timeout}); end
      @(posedge clock); #1;
   endtask

   task automatic test_back_to_back();
      int cyc, hv, bg; bit gd;
      cfg_wait = 0; cfg_lat = 0; slv_mem[0] = 32'h0000_0001; slv_mem[1] = EXP_TS;
      run_seq(1'b1, 20, 0, cyc, gd, hv, bg);
      n_checks++; if ({gd, id_ok, ts_ok} !== 3'b101) begin n_fail++; $display("FAIL b2b_first: done/id/ts %b expected 101", {gd, id_ok, ts_ok}); end
      n_checks++; if (id_value !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_first_id: got %h expected 00000001", id_value); end
      @(posedge clock); #1;
      slv_mem[0] = 32'd0; slv_mem[1] = 32'h0000_0000;
      run_seq(1'b1, 20, 0, cyc, gd, hv, bg);
      n_checks++; if ({gd, id_ok, ts_ok} !== 3'b110) begin n_fail++; $display("FAIL b2b_second: done/id/ts %b expected 110", {gd, id_ok, ts_ok}); end
      n_checks++; if (id_value !== 32'd0 || ts_value !== 32'd0) begin n_fail++; $display("FAIL b2b_second_vals: %h/%h expected 0/0", id_value, ts_value); end
      @(posedge clock); #1;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
`ifdef SYSID_CHECKER_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_repulse_stray();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
